// File: rtl/mem_access_unit.sv
// Memory-stage data access unit: converts MEM-stage load/store control into a req/ack
// bus transaction, with lane steering, load extension, stall generation and fault report.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadMEM,
  input  logic        MemWriteMEM,
  input  logic [1:0]  MemSizeMEM,
  input  logic        MemSignedMEM,
  input  logic [31:0] ALUoutMEM,
  input  logic [31:0] writedataMEM,
  output logic [31:0] memreaddataMEM,
  output logic        memstall,
  output logic        memfault,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack
);

  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_nxt;
  logic            r_fault;
  logic            w_fault_nxt;
  logic            r_req;
  logic            w_req_nxt;
  logic            r_we;
  logic [31:0]     r_addr;
  logic [3:0]      r_be;
  logic [31:0]     r_wdata;
  logic [1:0]      r_size;
  logic            r_signed;
  logic [1:0]      r_lane;
  logic [31:0]     r_rdata;
  logic [31:0]     w_rdata_nxt;
  logic            w_latch;
  logic            w_stall;

  logic            w_access;
  logic            w_misalign;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_load;

  assign w_access = MemReadMEM | MemWriteMEM;

  // Size 11 behaves as a word everywhere, so MemSizeMEM[1] alone identifies a word.
  always_comb begin
    w_misalign = 1'b0;
    w_be       = 4'b1111;
    w_wdata    = writedataMEM;
    unique case (MemSizeMEM)
      2'b00: begin
        w_be    = 4'b0001 << ALUoutMEM[1:0];
        w_wdata = {4{writedataMEM[7:0]}};
      end
      2'b01: begin
        w_misalign = ALUoutMEM[0];
        w_be       = ALUoutMEM[1] ? 4'b1100 : 4'b0011;
        w_wdata    = {2{writedataMEM[15:0]}};
      end
      default: begin
        w_misalign = (ALUoutMEM[1:0] != 2'b00);
      end
    endcase
  end

  always_comb begin
    unique case (r_lane)
      2'd0:    w_byte = dbus_rdata[7:0];
      2'd1:    w_byte = dbus_rdata[15:8];
      2'd2:    w_byte = dbus_rdata[23:16];
      default: w_byte = dbus_rdata[31:24];
    endcase
    w_half = r_lane[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    unique case (r_size)
      2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load = dbus_rdata;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fault_nxt = r_fault;
    w_req_nxt   = r_req;
    w_rdata_nxt = r_rdata;
    w_latch     = 1'b0;
    w_stall     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_access) begin
          w_stall   = 1'b1;
          w_cnt_nxt = '0;
          if (w_misalign) begin
            w_fault_nxt = 1'b1;
            w_state_nxt = StDone;
          end else begin
            w_fault_nxt = 1'b0;
            w_latch     = 1'b1;
            w_req_nxt   = 1'b1;
            w_state_nxt = StWait;
          end
        end
      end
      StWait: begin
        w_stall = 1'b1;
        // An ack arriving on the final allowed cycle takes priority over the timeout.
        if (dbus_ack) begin
          if (!r_we) begin
            w_rdata_nxt = w_load;
          end
          w_fault_nxt = 1'b0;
          w_req_nxt   = 1'b0;
          w_state_nxt = StDone;
        end else if (r_cnt == CntLast) begin
          w_rdata_nxt = '0;
          w_fault_nxt = 1'b1;
          w_req_nxt   = 1'b0;
          w_state_nxt = StDone;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_fault <= 1'b0;
      r_req   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_fault <= w_fault_nxt;
      r_req   <= w_req_nxt;
      r_rdata <= w_rdata_nxt;
    end
  end

  // Bus-side attributes only change when a new aligned access is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_be     <= '0;
      r_wdata  <= '0;
      r_size   <= '0;
      r_signed <= 1'b0;
      r_lane   <= '0;
    end else if (w_latch) begin
      r_we     <= MemWriteMEM;
      r_addr   <= {ALUoutMEM[31:2], 2'b00};
      r_be     <= w_be;
      r_wdata  <= w_wdata;
      r_size   <= MemSizeMEM;
      r_signed <= MemSignedMEM;
      r_lane   <= ALUoutMEM[1:0];
    end
  end

  assign memstall       = w_stall & reset;
  assign memfault       = (r_state == StDone) & r_fault;
  assign memreaddataMEM = r_rdata;
  assign dbus_req       = r_req;
  assign dbus_we        = r_we;
  assign dbus_addr      = r_addr;
  assign dbus_be        = r_be;
  assign dbus_wdata     = r_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed accesses push expectations, a monitor
// checks each completed access against them; reset behaviour is checked directly.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        MemReadMEM;
  logic        MemWriteMEM;
  logic [1:0]  MemSizeMEM;
  logic        MemSignedMEM;
  logic [31:0] ALUoutMEM;
  logic [31:0] writedataMEM;
  logic [31:0] memreaddataMEM;
  logic        memstall;
  logic        memfault;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic [31:0] dbus_rdata;
  logic        dbus_ack;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .MemReadMEM     (MemReadMEM),
    .MemWriteMEM    (MemWriteMEM),
    .MemSizeMEM     (MemSizeMEM),
    .MemSignedMEM   (MemSignedMEM),
    .ALUoutMEM      (ALUoutMEM),
    .writedataMEM   (writedataMEM),
    .memreaddataMEM (memreaddataMEM),
    .memstall       (memstall),
    .memfault       (memfault),
    .dbus_req       (dbus_req),
    .dbus_we        (dbus_we),
    .dbus_addr      (dbus_addr),
    .dbus_be        (dbus_be),
    .dbus_wdata     (dbus_wdata),
    .dbus_rdata     (dbus_rdata),
    .dbus_ack       (dbus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        chk_rd;
    logic        fault;
    int          stall;
    int          req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } exp_t;

  exp_t        q[$];
  int          checks;
  int          failures;
  logic        done_seen;
  int          slave_lat;
  logic [31:0] slave_rdata;
  int          s_cnt;

  int          stall_n;
  int          req_n;
  logic        prev_stall;
  logic        b_we;
  logic [31:0] b_addr;
  logic [3:0]  b_be;
  logic [31:0] b_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] rd, input logic chk_rd, input logic fault,
                              input int stall, input int req, input logic we,
                              input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wdata);
    exp_t e;
    e.rd = rd; e.chk_rd = chk_rd; e.fault = fault; e.stall = stall; e.req = req;
    e.we = we; e.addr = addr; e.be = be; e.wdata = wdata;
    return e;
  endfunction

  // Slave: acks on the slave_lat-th cycle that req is high (0 = never).
  initial begin
    dbus_ack   = 1'b0;
    dbus_rdata = '0;
    s_cnt      = 0;
    forever begin
      @(negedge clk);
      if (dbus_req) begin
        s_cnt++;
        if (slave_lat != 0 && s_cnt == slave_lat) begin
          dbus_ack   = 1'b1;
          dbus_rdata = slave_rdata;
        end else begin
          dbus_ack   = 1'b0;
          dbus_rdata = 32'h0BAD_0BAD;
        end
      end else begin
        s_cnt    = 0;
        dbus_ack = 1'b0;
      end
    end
  end

  // Monitor: the DONE cycle is the first non-stalled cycle after a stall with access still present.
  initial begin
    exp_t e;
    stall_n = 0; req_n = 0; prev_stall = 1'b0;
    b_we = 1'b0; b_addr = '0; b_be = '0; b_wdata = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall_n = 0; req_n = 0; prev_stall = 1'b0;
      end else begin
        if (dbus_req) begin
          req_n++;
          b_we = dbus_we; b_addr = dbus_addr; b_be = dbus_be; b_wdata = dbus_wdata;
        end
        if (memstall) begin
          stall_n++;
        end else if (prev_stall && (MemReadMEM || MemWriteMEM)) begin
          if (q.size() == 0) begin
            chk("unexpected_done", 32'(1), 32'(0));
          end else begin
            e = q.pop_front();
            chk("memfault", 32'(memfault), 32'(e.fault));
            chk("stall_cycles", 32'(stall_n), 32'(e.stall));
            chk("req_cycles", 32'(req_n), 32'(e.req));
            chk("req_low_in_done", 32'(dbus_req), 32'(0));
            if (e.chk_rd) chk("memreaddataMEM", memreaddataMEM, e.rd);
            if (e.req != 0) begin
              chk("dbus_we", 32'(b_we), 32'(e.we));
              chk("dbus_addr", b_addr, e.addr);
              chk("dbus_be", 32'(b_be), 32'(e.be));
              chk("dbus_wdata", b_wdata, e.wdata);
            end
          end
          done_seen = 1'b1;
          stall_n = 0; req_n = 0;
        end
        prev_stall = memstall;
      end
    end
  end

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd);
    MemReadMEM = rd; MemWriteMEM = wr; MemSizeMEM = sz; MemSignedMEM = sg;
    ALUoutMEM = addr; writedataMEM = wd;
  endtask

  task automatic run(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                     input logic [31:0] addr, input logic [31:0] wd, input int lat,
                     input logic [31:0] sr, input exp_t e);
    q.push_back(e);
    slave_lat   = lat;
    slave_rdata = sr;
    done_seen   = 1'b0;
    @(posedge clk);
    #1 drive(rd, wr, sz, sg, addr, wd);
    for (int i = 0; i < 50 && !done_seen; i++) @(posedge clk);
    if (!done_seen) begin
      chk("done_timeout", 32'(0), 32'(1));
      q.delete();
    end
    #1 drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("fault_one_cycle", 32'(memfault), 32'(0));
    chk("idle_no_stall", 32'(memstall), 32'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, 32'(dbus_req), 32'(0));
    chk({tag, "_we"}, 32'(dbus_we), 32'(0));
    chk({tag, "_addr"}, dbus_addr, 32'(0));
    chk({tag, "_be"}, 32'(dbus_be), 32'(0));
    chk({tag, "_wdata"}, dbus_wdata, 32'(0));
    chk({tag, "_rdata"}, memreaddataMEM, 32'(0));
    chk({tag, "_stall"}, 32'(memstall), 32'(0));
    chk({tag, "_fault"}, 32'(memfault), 32'(0));
  endtask

  initial begin
    checks = 0; failures = 0; done_seen = 1'b0; slave_lat = 0; slave_rdata = '0;
    reset = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 chk_all_zero("rst");
    @(negedge clk);
    reset = 1'b1;

    // Word load, ack first cycle.
    run(1, 0, 2'b10, 0, 32'h100, 32'h0, 1, 32'hDEADBEEF,
        mk(32'hDEADBEEF, 1, 0, 2, 1, 0, 32'h100, 4'b1111, 32'h0));
    // Byte load lane 3, signed then unsigned.
    run(1, 0, 2'b00, 1, 32'h103, 32'h0, 1, 32'h80112233,
        mk(32'hFFFFFF80, 1, 0, 2, 1, 0, 32'h100, 4'b1000, 32'h0));
    run(1, 0, 2'b00, 0, 32'h103, 32'h0, 1, 32'h80112233,
        mk(32'h00000080, 1, 0, 2, 1, 0, 32'h100, 4'b1000, 32'h0));
    // Half store with read also high: treated as store, load data untouched.
    run(1, 1, 2'b01, 0, 32'h202, 32'h0000ABCD, 2, 32'h12345678,
        mk(32'h00000080, 1, 0, 3, 2, 1, 32'h200, 4'b1100, 32'hABCDABCD));
    // Misaligned word load.
    run(1, 0, 2'b10, 0, 32'h101, 32'h0, 1, 32'h11111111,
        mk(32'h0, 0, 1, 1, 0, 0, 32'h0, 4'b0000, 32'h0));
    // Timeout with no ack.
    run(1, 0, 2'b10, 0, 32'h300, 32'h0, 0, 32'h0,
        mk(32'h0, 1, 1, 5, 4, 0, 32'h300, 4'b1111, 32'h0));
    // Ack on the final allowed cycle: signed upper half.
    run(1, 0, 2'b01, 1, 32'h306, 32'h0, 4, 32'h80017FFF,
        mk(32'hFFFF8001, 1, 0, 5, 4, 0, 32'h304, 4'b1100, 32'h0));
    run(0, 1, 2'b01, 0, 32'h010, 32'h12345678, 3, 32'h0,
        mk(32'hFFFF8001, 1, 0, 4, 3, 1, 32'h010, 4'b0011, 32'h56785678));
    run(0, 1, 2'b00, 0, 32'h021, 32'h000000AB, 1, 32'h0,
        mk(32'hFFFF8001, 1, 0, 2, 1, 1, 32'h020, 4'b0010, 32'hABABABAB));
    // Misaligned half store.
    run(0, 1, 2'b01, 0, 32'h011, 32'h0000FFFF, 1, 32'h0,
        mk(32'h0, 0, 1, 1, 0, 0, 32'h0, 4'b0000, 32'h0));
    run(1, 0, 2'b00, 0, 32'h001, 32'h0, 1, 32'h0000C300,
        mk(32'h000000C3, 1, 0, 2, 1, 0, 32'h000, 4'b0010, 32'h0));
    // Size 11 acts as word.
    run(1, 0, 2'b11, 1, 32'h008, 32'h0, 2, 32'hCAFEF00D,
        mk(32'hCAFEF00D, 1, 0, 3, 2, 0, 32'h008, 4'b1111, 32'h0));

    // Reset in the middle of a WAIT.
    slave_lat = 0;
    @(posedge clk);
    #1 drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #2 chk("req_before_reset", 32'(dbus_req), 32'(1));
    reset = 1'b0;
    #1 chk_all_zero("midrst");
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_stall", 32'(memstall), 32'(0));
    chk("post_rst_req", 32'(dbus_req), 32'(0));
    run(1, 0, 2'b10, 0, 32'h404, 32'h0, 1, 32'h600DF00D,
        mk(32'h600DF00D, 1, 0, 2, 1, 0, 32'h404, 4'b1111, 32'h0));

    if (q.size() != 0) chk("scoreboard_empty", 32'(q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
